// File: rtl/vram_rect_filler.sv
// Rectangle-fill writer for the frame-buffer VRAM: turns one fill command into
// row-major, one-pixel-per-clock writes, clipped to the visible frame.
module vram_rect_filler #(
  parameter int H_RES = 200,
  parameter int V_RES = 150,
  parameter int AW    = 15,
  parameter int DW    = 12
) (
  input  logic          clk_px,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_x,
  input  logic [7:0]    cmd_y,
  input  logic [7:0]    cmd_w,
  input  logic [7:0]    cmd_h,
  input  logic [DW-1:0] cmd_color,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          we,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;

  localparam logic [8:0]    H_LIM  = 9'(H_RES);
  localparam logic [8:0]    V_LIM  = 9'(V_RES);
  localparam logic [AW-1:0] H_STEP = AW'(H_RES);

  state_t        state, state_n;
  logic [7:0]    x_q, y_q, w_q, h_q, x_n, y_n, w_n, h_n;
  logic [DW-1:0] color_q, color_n;
  logic [8:0]    x_end_q, y_end_q, x_end_n, y_end_n;
  logic [7:0]    cx, cy, cx_n, cy_n;
  logic [AW-1:0] row_base, row_base_n;
  logic [AW-1:0] waddr_n;
  logic [DW-1:0] wdata_n;
  logic          we_n, busy_n, done_n, ready_n;

  logic [8:0]    x_sum, y_sum, x_end_c, y_end_c;
  logic [AW-1:0] y_ext, row_base_c;
  logic          empty, last_col, last_row;

  always_ff @(posedge clk_px or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      color_q   <= '0;
      x_end_q   <= '0;
      y_end_q   <= '0;
      cx        <= '0;
      cy        <= '0;
      row_base  <= '0;
      waddr     <= '0;
      wdata     <= '0;
      we        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= state_n;
      x_q       <= x_n;
      y_q       <= y_n;
      w_q       <= w_n;
      h_q       <= h_n;
      color_q   <= color_n;
      x_end_q   <= x_end_n;
      y_end_q   <= y_end_n;
      cx        <= cx_n;
      cy        <= cy_n;
      row_base  <= row_base_n;
      waddr     <= waddr_n;
      wdata     <= wdata_n;
      we        <= we_n;
      busy      <= busy_n;
      done      <= done_n;
      cmd_ready <= ready_n;
    end
  end

  // Outputs are registered, so each state computes the write that appears on the next cycle.
  always_comb begin
    state_n    = state;
    x_n        = x_q;
    y_n        = y_q;
    w_n        = w_q;
    h_n        = h_q;
    color_n    = color_q;
    x_end_n    = x_end_q;
    y_end_n    = y_end_q;
    cx_n       = cx;
    cy_n       = cy;
    row_base_n = row_base;
    waddr_n    = waddr;
    wdata_n    = wdata;
    we_n       = we;
    busy_n     = busy;
    done_n     = done;
    ready_n    = cmd_ready;

    x_sum      = {1'b0, x_q} + {1'b0, w_q};
    y_sum      = {1'b0, y_q} + {1'b0, h_q};
    x_end_c    = (x_sum > H_LIM) ? H_LIM : x_sum;
    y_end_c    = (y_sum > V_LIM) ? V_LIM : y_sum;
    empty      = (w_q == 8'd0) || (h_q == 8'd0) || ({1'b0, x_q} >= H_LIM) || ({1'b0, y_q} >= V_LIM);
    y_ext      = AW'(y_q);
    row_base_c = (y_ext << 7) + (y_ext << 6) + (y_ext << 3);
    last_col   = (({1'b0, cx} + 9'd1) == x_end_q);
    last_row   = (({1'b0, cy} + 9'd1) == y_end_q);

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          x_n     = cmd_x;
          y_n     = cmd_y;
          w_n     = cmd_w;
          h_n     = cmd_h;
          color_n = cmd_color;
          busy_n  = 1'b1;
          ready_n = 1'b0;
          state_n = CLIP;
        end
      end
      CLIP: begin
        x_end_n = x_end_c;
        y_end_n = y_end_c;
        if (empty) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          row_base_n = row_base_c;
          cx_n       = x_q;
          cy_n       = y_q;
          waddr_n    = row_base_c + AW'(x_q);
          wdata_n    = color_q;
          we_n       = 1'b1;
          state_n    = FILL;
        end
      end
      FILL: begin
        if (last_col && last_row) begin
          we_n    = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end else if (last_col) begin
          cx_n       = x_q;
          cy_n       = cy + 8'd1;
          row_base_n = row_base + H_STEP;
          waddr_n    = row_base + H_STEP + AW'(x_q);
        end else begin
          cx_n    = cx + 8'd1;
          waddr_n = row_base + AW'(cx + 8'd1);
        end
      end
      DONE: begin
        done_n  = 1'b0;
        ready_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
